// File: rtl/spi_sched_pkg.sv
// Shared types and defaults for the SPI sample scheduler: FSM states,
// the trim command header and the transaction-length helper.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADC_XFER,
        GAP1,
        DAC_XFER,
        GAP2,
        TRIM_XFER
    } state_t;

    localparam logic [1:0] TRIM_CMD_HDR = 2'b11;

    localparam int unsigned DEF_SCLK_DIV   = 4;
    localparam int unsigned DEF_FRAME_BITS = 16;
    localparam int unsigned DEF_TRIM_BITS  = 8;
    localparam int unsigned DEF_GAP_CYCLES = 2;

    function automatic int unsigned frame_cycles(input int unsigned sclk_div,
                                                 input int unsigned frame_bits);
        return 2 * sclk_div * (frame_bits + 1);
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Generic SPI mode-0 shifter, MSB first: one setup half, FRAME_BITS low/high
// half pairs, one hold half; each half lasts SCLK_DIV clk cycles.
module spi_shift_engine #(
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_word,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [FRAME_BITS-1:0] rx_word,
    output logic                  done
);

    localparam int unsigned LAST_HALF = 2 * FRAME_BITS + 1;
    localparam int unsigned HW = $clog2(LAST_HALF + 1);
    localparam int unsigned SW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic                  active;
    logic [HW-1:0]         half;
    logic [HW-1:0]         half_nxt;
    logic [SW-1:0]         sub;
    logic                  half_end;
    logic [FRAME_BITS-1:0] tx_sr;

    assign half_end = (sub == SW'(SCLK_DIV - 1));
    assign half_nxt = half + 1'b1;
    // Last cycle of the hold half: the owner raises CS on the following edge.
    assign done     = active && half_end && (half == HW'(LAST_HALF));

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            half    <= '0;
            sub     <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            tx_sr   <= '0;
            rx_word <= '0;
        end else if (start) begin
            active  <= 1'b1;
            half    <= '0;
            sub     <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            tx_sr   <= tx_word;
            rx_word <= '0;
        end else if (active) begin
            if (!half_end) begin
                sub <= sub + 1'b1;
            end else begin
                sub <= '0;
                if (done) begin
                    active <= 1'b0;
                    half   <= '0;
                    sclk   <= 1'b0;
                    mosi   <= 1'b0;
                end else begin
                    half <= half_nxt;
                    // Odd halves are sclk-low bit halves, even ones sclk-high.
                    if (half_nxt == HW'(LAST_HALF)) begin
                        sclk <= 1'b0;
                        mosi <= 1'b0;
                    end else if (half_nxt[0]) begin
                        sclk  <= 1'b0;
                        mosi  <= tx_sr[FRAME_BITS-1];
                        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                    end else begin
                        sclk    <= 1'b1;
                        rx_word <= {rx_word[FRAME_BITS-2:0], miso};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_sample_scheduler.sv
// Per-sample SPI frame sequencer: ADC read, DAC write, then one round-robin
// trim pot read. Optional macro TRIM_HYST_EN suppresses trim changes below 2.
module spi_sample_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned SCLK_DIV   = DEF_SCLK_DIV,
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned TRIM_BITS  = DEF_TRIM_BITS,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_clock,
    input  logic [FRAME_BITS-1:0] dac_data,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sclk,
    output logic                  cs_adc_n,
    output logic                  cs_dac_n,
    output logic                  cs_trim_n,
    output logic [FRAME_BITS-1:0] adc,
    output logic                  adc_valid,
    output logic [TRIM_BITS-1:0]  trim1,
    output logic [TRIM_BITS-1:0]  trim2,
    output logic [TRIM_BITS-1:0]  trim3,
    output logic [TRIM_BITS-1:0]  trim4,
    output logic                  trim_valid,
    output logic [1:0]            mux,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t                state;
    logic                  adc_clock_q;
    logic                  strobe;
    logic [FRAME_BITS-1:0] dac_q;
    logic [GW-1:0]         gap_cnt;
    logic                  gap_end;
    logic [TRIM_BITS-1:0]  trim_r [4];
    logic                  trim_done_q;
    logic                  trim_upd;
    logic                  start;
    logic [FRAME_BITS-1:0] tx_word;
    logic [FRAME_BITS-1:0] trim_cmd;
    logic [FRAME_BITS-1:0] rx_word;
    logic                  eng_done;

    assign strobe  = adc_clock & ~adc_clock_q;
    assign gap_end = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign busy    = (state != IDLE);
    assign trim1   = trim_r[0];
    assign trim2   = trim_r[1];
    assign trim3   = trim_r[2];
    assign trim4   = trim_r[3];

    always_comb begin
        trim_cmd = '0;
        trim_cmd[FRAME_BITS-1 -: 4] = {TRIM_CMD_HDR, mux};
    end

    // Engine start and payload are decoded on the same edge that drops CS.
    always_comb begin
        start   = 1'b0;
        tx_word = '0;
        case (state)
            IDLE: start = strobe;
            GAP1: if (gap_end) begin
                start   = 1'b1;
                tx_word = dac_q;
            end
            GAP2: if (gap_end) begin
                start   = 1'b1;
                tx_word = trim_cmd;
            end
            default: ;
        endcase
    end

`ifdef TRIM_HYST_EN
    logic [TRIM_BITS-1:0] trim_new;
    logic [TRIM_BITS-1:0] trim_old;
    logic [TRIM_BITS-1:0] trim_diff;

    always_comb begin
        trim_new  = rx_word[TRIM_BITS-1:0];
        trim_old  = trim_r[mux];
        trim_diff = (trim_new >= trim_old) ? (trim_new - trim_old) : (trim_old - trim_new);
        trim_upd  = (trim_diff >= TRIM_BITS'(2));
    end
`else
    assign trim_upd = 1'b1;
`endif

    spi_shift_engine #(
        .SCLK_DIV   (SCLK_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_word (tx_word),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .rx_word (rx_word),
        .done    (eng_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            adc_clock_q <= 1'b0;
            dac_q       <= '0;
            gap_cnt     <= '0;
            cs_adc_n    <= 1'b1;
            cs_dac_n    <= 1'b1;
            cs_trim_n   <= 1'b1;
            adc         <= '0;
            adc_valid   <= 1'b0;
            trim_valid  <= 1'b0;
            trim_done_q <= 1'b0;
            mux         <= '0;
            overrun     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) trim_r[i] <= '0;
        end else begin
            adc_clock_q <= adc_clock;
            adc_valid   <= 1'b0;
            trim_valid  <= 1'b0;
            trim_done_q <= 1'b0;
            if (trim_done_q) mux <= mux + 2'd1;
            if (strobe && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: if (strobe) begin
                    dac_q    <= dac_data;
                    cs_adc_n <= 1'b0;
                    state    <= ADC_XFER;
                end
                ADC_XFER: if (eng_done) begin
                    cs_adc_n  <= 1'b1;
                    adc       <= rx_word;
                    adc_valid <= 1'b1;
                    gap_cnt   <= '0;
                    state     <= GAP1;
                end
                GAP1: if (gap_end) begin
                    cs_dac_n <= 1'b0;
                    state    <= DAC_XFER;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                DAC_XFER: if (eng_done) begin
                    cs_dac_n <= 1'b1;
                    gap_cnt  <= '0;
                    state    <= GAP2;
                end
                GAP2: if (gap_end) begin
                    cs_trim_n <= 1'b0;
                    state     <= TRIM_XFER;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                TRIM_XFER: if (eng_done) begin
                    cs_trim_n   <= 1'b1;
                    trim_done_q <= 1'b1;
                    if (trim_upd) begin
                        trim_r[mux] <= rx_word[TRIM_BITS-1:0];
                        trim_valid  <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Scoreboard bench for spi_sample_scheduler with an SPI slave model on miso
// and a mosi capture monitor; honours TRIM_HYST_EN in its trim model.
module tb_spi_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_clock;
    logic [15:0] dac_data;
    logic        miso;
    logic        mosi, sclk, cs_adc_n, cs_dac_n, cs_trim_n;
    logic [15:0] adc;
    logic        adc_valid, trim_valid, busy, overrun;
    logic [7:0]  trim1, trim2, trim3, trim4;
    logic [1:0]  mux;

    always #5 clk = ~clk;

    spi_sample_scheduler #(
        .SCLK_DIV   (4),
        .FRAME_BITS (16),
        .TRIM_BITS  (8),
        .GAP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_clock  (adc_clock),
        .dac_data   (dac_data),
        .miso       (miso),
        .mosi       (mosi),
        .sclk       (sclk),
        .cs_adc_n   (cs_adc_n),
        .cs_dac_n   (cs_dac_n),
        .cs_trim_n  (cs_trim_n),
        .adc        (adc),
        .adc_valid  (adc_valid),
        .trim1      (trim1),
        .trim2      (trim2),
        .trim3      (trim3),
        .trim4      (trim4),
        .trim_valid (trim_valid),
        .mux        (mux),
        .busy       (busy),
        .overrun    (overrun)
    );

    typedef struct {
        logic [1:0] slot;
        logic [7:0] val;
    } trim_exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] q_adc [$];
    logic [15:0] q_dac [$];
    logic [15:0] q_hdr [$];
    logic [1:0]  q_mux [$];
    trim_exp_t   q_trim [$];
    logic [7:0]  model_trim [4];
    logic [1:0]  slot;
    logic [15:0] adc_resp;
    logic [7:0]  trim_resp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] trim_reg(input logic [1:0] s);
        case (s)
            2'd0:    return trim1;
            2'd1:    return trim2;
            2'd2:    return trim3;
            default: return trim4;
        endcase
    endfunction

    // SPI slave + protocol monitor, evaluated between clk edges
    initial begin
        logic        p_adc, p_dac, p_trim, p_sclk;
        logic [15:0] sr, cap;
        logic [15:0] e16;
        trim_exp_t   te;
        int          nbits, nlow;
        p_adc = 1'b1; p_dac = 1'b1; p_trim = 1'b1; p_sclk = 1'b0;
        sr = '0; cap = '0; nbits = 0;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                miso = 1'b0;
            end else begin
                nlow = int'(!cs_adc_n) + int'(!cs_dac_n) + int'(!cs_trim_n);
                check("cs_onehot", 32'(nlow <= 1), 1);
                check("sclk_idle", 32'(sclk & cs_adc_n & cs_dac_n & cs_trim_n), 0);
                check("sclk_quiet", 32'((sclk ^ p_sclk) & p_adc & p_dac & p_trim), 0);

                if (p_adc && !cs_adc_n) begin
                    sr = adc_resp; cap = '0; nbits = 0; miso = sr[15];
                end
                if (p_dac && !cs_dac_n) begin
                    sr = 16'($urandom); cap = '0; nbits = 0; miso = sr[15];
                end
                if (p_trim && !cs_trim_n) begin
                    sr = {8'h00, trim_resp}; cap = '0; nbits = 0; miso = sr[15];
                    if (q_mux.size() == 0) check("mux_unexpected", 0, 1);
                    else check("mux", 32'(mux), 32'(q_mux.pop_front()));
                end
                if (sclk && !p_sclk) begin
                    cap = {cap[14:0], mosi};
                    nbits++;
                end
                if (!sclk && p_sclk) begin
                    sr = {sr[14:0], 1'b0};
                    miso = sr[15];
                end

                if (!p_adc && cs_adc_n) begin
                    check("adc_bits", nbits, 16);
                    check("adc_mosi", 32'(cap), 0);
                end
                if (!p_dac && cs_dac_n) begin
                    check("dac_bits", nbits, 16);
                    if (q_dac.size() == 0) check("dac_unexpected", 0, 1);
                    else begin e16 = q_dac.pop_front(); check("dac_mosi", 32'(cap), 32'(e16)); end
                end
                if (!p_trim && cs_trim_n) begin
                    check("trim_bits", nbits, 16);
                    if (q_hdr.size() == 0) check("hdr_unexpected", 0, 1);
                    else begin e16 = q_hdr.pop_front(); check("trim_hdr", 32'(cap), 32'(e16)); end
                end
                if (adc_valid) begin
                    if (q_adc.size() == 0) check("adc_valid_unexpected", 0, 1);
                    else begin e16 = q_adc.pop_front(); check("adc", 32'(adc), 32'(e16)); end
                end
                if (trim_valid) begin
                    if (q_trim.size() == 0) check("trim_valid_unexpected", 0, 1);
                    else begin
                        te = q_trim.pop_front();
                        check("trim_val", 32'(trim_reg(te.slot)), 32'(te.val));
                        check("trim_slot", 32'(mux), 32'(te.slot));
                    end
                end
            end
            p_adc = cs_adc_n; p_dac = cs_dac_n; p_trim = cs_trim_n; p_sclk = sclk;
        end
    end

    task automatic run_frame(input logic [15:0] a, input logic [15:0] d, input logic [7:0] t,
                             input int second_at, input int abort_at);
        int         n = 0;
        int         adc_at = -1;
        logic       upd;
        logic [7:0] old, diff;
        logic       aborted = 1'b0;
        adc_resp  = a;
        trim_resp = t;
        dac_data  = d;
        q_adc.push_back(a);
        q_dac.push_back(d);
        q_hdr.push_back({2'b11, slot, 12'h000});
        q_mux.push_back(slot);
        old  = model_trim[slot];
        diff = (t >= old) ? (t - old) : (old - t);
`ifdef TRIM_HYST_EN
        upd = (diff >= 8'd2);
`else
        upd = 1'b1 | diff[0];
`endif
        if (upd && abort_at == 0) begin
            model_trim[slot] = t;
            q_trim.push_back('{slot, t});
        end
        adc_clock = 1'b0;
        @(posedge clk); #1;
        adc_clock = 1'b1;
        @(posedge clk); #1;
        check("busy_start", 32'(busy), 1);
        while (busy && n < 1000 && !aborted) begin
            @(posedge clk); #1;
            n++;
            if (n == 10) adc_clock = 1'b0;
            if (second_at != 0 && n == second_at) adc_clock = 1'b1;
            if (second_at != 0 && n == second_at + 5) adc_clock = 1'b0;
            if (adc_valid) adc_at = n;
            if (abort_at != 0 && n == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk); #1;
                rst = 1'b0;
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            check("abort_cs", 32'({cs_adc_n, cs_dac_n, cs_trim_n}), 32'h7);
            check("abort_sclk", 32'(sclk), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_valids", 32'({adc_valid, trim_valid}), 0);
            check("abort_mux", 32'(mux), 0);
            check("abort_overrun", 32'(overrun), 0);
            check("abort_adc", 32'(adc), 0);
            q_dac.delete(); q_hdr.delete(); q_mux.delete(); q_trim.delete(); q_adc.delete();
            for (int i = 0; i < 4; i++) model_trim[i] = 8'h00;
            slot = 2'd0;
            repeat (40) @(posedge clk);
            #1;
            check("abort_idle", 32'(busy), 0);
        end else begin
            check("adc_valid_cycle", adc_at, 136);
            check("frame_len", n, 412);
            @(posedge clk); #1;
            slot = slot + 2'd1;
            check("mux_next", 32'(mux), 32'(slot));
            check("queues_empty", q_adc.size() + q_dac.size() + q_hdr.size()
                                  + q_mux.size() + q_trim.size(), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        adc_clock = 1'b0;
        dac_data  = 16'h0000;
        adc_resp  = 16'h0000;
        trim_resp = 8'h00;
        slot      = 2'd0;
        for (int i = 0; i < 4; i++) model_trim[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'({cs_adc_n, cs_dac_n, cs_trim_n}), 32'h7);
        check("rst_spi", 32'({sclk, mosi}), 0);
        check("rst_adc", 32'(adc), 0);
        check("rst_trims", {trim1, trim2, trim3, trim4}, 0);
        check("rst_flags", 32'({adc_valid, trim_valid, busy, overrun}), 0);
        check("rst_mux", 32'(mux), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(16'hA5C3, 16'h1234, 8'h10, 0, 0);
        run_frame(16'h0F0F, 16'hFFFF, 8'h20, 0, 0);
        run_frame(16'h8001, 16'h0001, 8'h30, 0, 0);
        run_frame(16'h7FFE, 16'h8000, 8'h40, 0, 0);
        check("trim1_all", 32'(trim1), 32'h10);
        check("trim2_all", 32'(trim2), 32'h20);
        check("trim3_all", 32'(trim3), 32'h30);
        check("trim4_all", 32'(trim4), 32'h40);
        check("overrun_clear", 32'(overrun), 0);
        run_frame(16'h5555, 16'hBEEF, 8'h18, 0, 0);

        run_frame(16'h1357, 16'h2468, 8'h77, 200, 0);
        check("overrun_set", 32'(overrun), 1);
        repeat (30) @(posedge clk);
        #1;
        check("no_extra_frame", 32'(busy), 0);

        run_frame(16'hCAFE, 16'hD00D, 8'h99, 0, 200);
        run_frame(16'h3C3C, 16'h6A6A, 8'h21, 0, 0);
        check("post_abort_overrun", 32'(overrun), 0);

        while (slot != 2'd0) run_frame(16'($urandom), 16'($urandom), 8'($urandom), 0, 0);
        run_frame(16'h0001, 16'h0002, 8'h50, 0, 0);
        run_frame(16'h0003, 16'h0004, 8'h60, 0, 0);
        run_frame(16'h0005, 16'h0006, 8'h61, 0, 0);
        run_frame(16'h0007, 16'h0008, 8'h62, 0, 0);
        run_frame(16'h0009, 16'h000A, 8'h51, 0, 0);
`ifdef TRIM_HYST_EN
        check("hyst_hold", 32'(trim1), 32'h50);
`else
        check("hyst_hold", 32'(trim1), 32'h51);
`endif
        run_frame(16'h000B, 16'h000C, 8'h60, 0, 0);
        run_frame(16'h000D, 16'h000E, 8'h61, 0, 0);
        run_frame(16'h000F, 16'h0010, 8'h62, 0, 0);
        run_frame(16'h0011, 16'h0012, 8'h53, 0, 0);
        check("hyst_update", 32'(trim1), 32'h53);
        check("final_trim1", 32'(trim1), 32'(model_trim[0]));
        check("final_trim2", 32'(trim2), 32'(model_trim[1]));
        check("final_trim3", 32'(trim3), 32'(model_trim[2]));
        check("final_trim4", 32'(trim4), 32'(model_trim[3]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_sample_scheduler.md
Name: spi_sample_scheduler

Overview:
Per-sample sequencer that shares one SPI bus among three requesters: the ADC read, the DAC write, and a round-robin read of the four trim pots. On each rising edge of the adc_clock sample strobe it runs a fixed frame: ADC, then DAC, then one trim pot. It drives the pedal's off-chip SPI pins. It feeds adc samples into the compression/adder datapath and trim values to the controller.

Parameters:
SCLK_DIV, 4, clk cycles per sclk half-period (>=1)
FRAME_BITS, 16, bits per SPI transaction (all three types)
TRIM_BITS, 8, trim value width, taken from the LSBs of the trim frame
GAP_CYCLES, 2, idle cycles with all CS high between transactions

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, synchronous, active-high
adc_clock  in  1  sample strobe, synchronous to clk; a frame starts on its rising edge
dac_data  in  16  next DAC sample, latched at frame start
miso  in  1  SPI serial in
mosi  out  1  SPI serial out
sclk  out  1  SPI clock, mode 0
cs_adc_n  out  1  ADC chip select, active low
cs_dac_n  out  1  DAC chip select, active low
cs_trim_n  out  1  trim-pot ADC chip select, active low
adc  out  16  last ADC sample
adc_valid  out  1  1-cycle pulse when adc updates
trim1, trim2, trim3, trim4  out  8 each  last trim pot values
trim_valid  out  1  1-cycle pulse when a trim register updates
mux  out  2  index (0..3) of the trim slot read in the current or last frame
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky; set when a strobe arrives while busy

Behaviour:
- Reset (sync, rst=1 at a clk edge), next cycle: state IDLE, sclk=0, mosi=0, all CS=1, adc=0, trim1..4=0, adc_valid=0, trim_valid=0, mux=0, busy=0, overrun=0. Reset mid-transaction aborts immediately; no valid pulse is issued.
- Strobe detect: adc_clock_q registers adc_clock; strobe = adc_clock & ~adc_clock_q.
  - Accepted only in IDLE: latch dac_data and go to ADC_XFER.
  - Strobe in any other state: set overrun. The strobe is dropped and the running frame continues. overrun clears only on rst.
- FSM: IDLE -> ADC_XFER -> GAP1 -> DAC_XFER -> GAP2 -> TRIM_XFER -> IDLE. Each GAP lasts GAP_CYCLES cycles.
- Transaction timing (SPI mode 0, MSB first):
  - CS falls at transaction start.
  - SCLK_DIV setup cycles follow, then FRAME_BITS bits of 2*SCLK_DIV cycles each: sclk low half, then high half.
  - mosi is updated at the start of each low half. miso is sampled on the cycle sclk rises.
  - After the last high half: SCLK_DIV hold cycles with sclk low, then CS rises.
  - Transaction length: 2*SCLK_DIV*(FRAME_BITS+1) cycles; defaults give 136.
  - Full frame with defaults: 3*136 + 2*2 = 412 cycles. The adc_clock period must exceed this; otherwise overrun.
- ADC frame: mosi held 0. The 16 captured bits load into adc on the cycle CS rises. adc_valid pulses that same cycle.
- DAC frame: mosi shifts the latched dac_data. miso is ignored.
- TRIM frame:
  - mosi sends {2'b11, mux[1:0], 12'h000}.
  - The captured frame's [7:0] loads into trim(mux+1) on the cycle CS rises; trim_valid pulses that same cycle.
  - mux increments (wraps 3->0) on the following cycle. A full pot refresh therefore takes 4 frames.
- At most one CS is low at any time. sclk=0 whenever all CS are high.

Optional Feature:
Macro TRIM_HYST_EN.
- Defined: a trim register updates, and trim_valid pulses, only when |new - stored| >= 2. Smaller changes are discarded to suppress pot jitter.
- Not defined: every trim frame updates its register and pulses trim_valid.
- mux advances in both cases.

Decomposition:
- Package spi_sched_pkg holds:
  - state encoding (IDLE, ADC_XFER, GAP1, DAC_XFER, GAP2, TRIM_XFER)
  - TRIM_CMD_HDR = 2'b11
  - default widths and the frame-length function
- Sub-module spi_shift_engine: a generic FRAME_BITS mode-0 shifter.
  - Inputs: start, tx_word, SCLK_DIV.
  - Outputs: sclk, mosi, rx_word, done (1-cycle pulse when CS would rise).
- The scheduler owns the FSM, CS steering, result registers, overrun and the hysteresis logic.

Test Plan:
- Reset then one strobe, miso model returning 16'hA5C3 on ADC, dac_data=16'h1234 -> adc=16'hA5C3 with adc_valid pulse at cycle 136 after acceptance; DAC mosi stream equals 0x1234 MSB first; busy low after 412 cycles.
- Four frames with the trim model returning 8'h10, 8'h20, 8'h30, 8'h40 -> trim1..4 hold those values; mux sequence 0,1,2,3,0; mosi headers 0xC000, 0xD000, 0xE000, 0xF000.
- Second strobe 200 cycles into a frame -> overrun=1; the frame completes normally; no extra frame starts.
- rst asserted mid-DAC transaction -> next cycle all CS=1, sclk=0, state IDLE, no valid pulses; a fresh strobe then runs a complete frame.
- Checker on every cycle -> at most one CS low; sclk only toggles while a CS is low; miso sampled only on sclk rise.
- TRIM_HYST_EN defined, trim1=8'h50 stored, next read 8'h51 -> no update, no trim_valid; next read 8'h53 -> trim1=8'h53 with trim_valid pulse.
